// File: rtl/vga_balayage.sv
// VGA raster stage: pixel scan counters, sync generation and a registered,
// blanked RGB output stage around an external colour decoder.
module vga_balayage #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [2:0] rouge_in,
  input  logic [2:0] vert_in,
  input  logic [1:0] bleu_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       actif,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rouge,
  output logic [2:0] vert,
  output logic [1:0] bleu,
  output logic       debut_trame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The 10-bit counters cannot represent a longer line or frame.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_balayage: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [2:0] rouge_q, rouge_d;
  logic [2:0] vert_q, vert_d;
  logic [1:0] bleu_q, bleu_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       debut_q, debut_d;
  logic       h_wrap, v_wrap;
  logic       actif_w;

  // Visible-area flag straight from the registered counters.
  always_comb begin
    actif_w = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  end

  // Next-state: counters advance and the output stage samples only on pix_en;
  // the frame-start pulse defaults low so it lasts a single clk.
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    rouge_d = rouge_q;
    vert_d  = vert_q;
    bleu_d  = bleu_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    debut_d = 1'b0;
    h_wrap  = (hcnt_q == H_LAST);
    v_wrap  = (vcnt_q == V_LAST);
    if (pix_en) begin
      hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
      end
      rouge_d = actif_w ? rouge_in : 3'd0;
      vert_d  = actif_w ? vert_in  : 3'd0;
      bleu_d  = actif_w ? bleu_in  : 2'd0;
      hsync_d = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      debut_d = h_wrap && v_wrap;
    end
  end

  // State registers; reset overrides pix_en and any in-progress sync pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      rouge_q <= 3'd0;
      vert_q  <= 3'd0;
      bleu_q  <= 2'd0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      debut_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      rouge_q <= rouge_d;
      vert_q  <= vert_d;
      bleu_q  <= bleu_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      debut_q <= debut_d;
    end
  end

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign actif       = actif_w;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rouge       = rouge_q;
  assign vert        = vert_q;
  assign bleu        = bleu_q;
  assign debut_trame = debut_q;

endmodule

// File: tb/tb_vga_balayage.sv
// Bench for vga_balayage with reduced timing so whole frames fit in a short run.
module tb_vga_balayage;

  localparam int HA = 200, HF = 8, HS = 12, HB = 10;
  localparam int VA = 12,  VF = 2, VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n, pix_en;
  logic [2:0] rouge_in, vert_in;
  logic [1:0] bleu_in;
  logic [9:0] x, y;
  logic       actif, hsync, vsync, debut_trame;
  logic [2:0] rouge, vert;
  logic [1:0] bleu;

  vga_balayage #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .rouge_in(rouge_in), .vert_in(vert_in), .bleu_in(bleu_in),
    .x(x), .y(y), .actif(actif), .hsync(hsync), .vsync(vsync),
    .rouge(rouge), .vert(vert), .bleu(bleu), .debut_trame(debut_trame)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int         mx, my;
  logic [7:0] m_rgb;
  logic       m_hs, m_vs, m_deb;
  logic       pat_mode;
  int         cyc = 0;
  int         hs_run, vs_run;
  int         deb_cnt = 0;
  int         last_deb = -1;
  int         exp_period = FRAME;
  logic       chk_period = 1'b1;
  logic       reached;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clk: drive inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic pe, input logic rst);
    logic [2:0] r, g;
    logic [1:0] b;
    logic       act;
    logic [W-1:0] obs;
    if (pat_mode) begin
      r = 3'(mx % 8);
      g = 3'((mx / 8) % 8);
      b = 2'((mx / 64) % 4);
    end else begin
      r = 3'd7; g = 3'd7; b = 2'd3;
    end
    rouge_in = r; vert_in = g; bleu_in = b;
    pix_en = pe;
    rst_n = ~rst;
    act = (mx < HA) && (my < VA);
    if (rst) begin
      mx = 0; my = 0; m_rgb = 8'd0; m_hs = 1'b1; m_vs = 1'b1; m_deb = 1'b0;
    end else if (pe) begin
      m_rgb = act ? {r, g, b} : 8'd0;
      m_hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
      m_vs  = !((my >= VA + VF) && (my < VA + VF + VS));
      m_deb = (mx == HT - 1) && (my == VT - 1);
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end else begin
      m_deb = 1'b0;
    end
    exp_q.push_back({10'(mx), 10'(my), 1'((mx < HA) && (my < VA)), m_hs, m_vs, m_rgb, m_deb});
    @(posedge clk);
    #1;
    cyc++;
    obs = {x, y, actif, hsync, vsync, rouge, vert, bleu, debut_trame};
    chk("scan", obs, exp_q.pop_front());
    if (rst) begin
      hs_run = 0; vs_run = 0;
    end else if (pe) begin
      if (!hsync) hs_run++;
      else if (hs_run != 0) begin chk("hsync_width", 32'(hs_run), 32'(HS)); hs_run = 0; end
      if (!vsync) vs_run++;
      else if (vs_run != 0) begin chk("vsync_width", 32'(vs_run), 32'(VS * HT)); vs_run = 0; end
    end
    if (debut_trame) begin
      deb_cnt++;
      if (chk_period && last_deb >= 0) chk("frame_period", 32'(cyc - last_deb), 32'(exp_period));
      last_deb = chk_period ? cyc : -1;
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0;
    rouge_in = 3'd0; vert_in = 3'd0; bleu_in = 2'd0;
    pat_mode = 1'b0;
    mx = 0; my = 0; hs_run = 0; vs_run = 0;
    #2;

    // reset, including one cycle with pix_en high to show reset wins
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    last_deb = cyc;

    // two full frames at full pixel rate, constant white input
    exp_period = FRAME;
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0);
    chk("debut_count_full", 32'(deb_cnt), 32'd2);

    // half-rate pix_en: frame period doubles, outputs hold on idle cycles
    exp_period = 2 * FRAME;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    chk("debut_count_half", 32'(deb_cnt), 32'd4);

    // colour pattern, then reset in the middle of an hsync pulse
    pat_mode = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      if (mx == HA + HF + 5 && my == 5) reached = 1'b1;
      else step(1'b1, 1'b0);
    end
    chk("reach_hsync", 32'(reached), 32'd1);
    chk("in_hsync_before_reset", 32'(hsync), 32'd0);
    step(1'b1, 1'b1);
    last_deb = cyc;
    exp_period = FRAME;
    for (int i = 0; i < FRAME + 5; i++) step(1'b1, 1'b0);
    chk("debut_count_after_reset", 32'(deb_cnt), 32'd5);

    // random pixel enable with the colour pattern
    chk_period = 1'b0;
    for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
